// File: rtl/pwm_multi_pkg.sv
// Shared constants for pwm_multi: register map, control bit positions, LFSR
// parameters and the dither-strength to shift mapping.
package pwm_multi_pkg;

  localparam logic [7:0] ADDR_CTL   = 8'h00;
  localparam logic [7:0] ADDR_PRESC = 8'h01;
  localparam logic [7:0] CH_BASE    = 8'h10;
  localparam int         CH_STRIDE  = 4;

  localparam logic [1:0] OFF_DUTY_H = 2'd0;
  localparam logic [1:0] OFF_DUTY_L = 2'd1;
  localparam logic [1:0] OFF_CHCTL  = 2'd2;

  localparam int CTL_EN_BIT     = 7;
  localparam int CTL_CENTER_BIT = 6;
  localparam int CHCTL_INV_BIT  = 0;
  localparam int CHCTL_CHEN_BIT = 1;

  localparam logic [7:0] LFSR_SEED = 8'hFF;
  localparam logic [7:0] LFSR_TAPS = 8'h1D;

  // A shift of 8 clears the whole 8-bit LFSR value, i.e. dither off.
  function automatic logic [3:0] ds_shift(input logic [1:0] ds);
    case (ds)
      2'd3:    return 4'd1;
      2'd2:    return 4'd3;
      2'd1:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/pwm_multi_lfsr.sv
// 8-bit Galois LFSR used as the dither source; only built when PWM_DITHER_EN
// is defined, since nothing else instantiates it.
`ifdef PWM_DITHER_EN
module pwm_lfsr8
  import pwm_multi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  output logic [7:0] lfsr_o
);
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) lfsr_d = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? LFSR_TAPS : 8'h00);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
endmodule
`endif

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared prescaler/counter, shadowed atomic duty writes,
// edge/centre modes and optional LFSR dither (enabled by macro PWM_DITHER_EN).
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int PWM_BITS   = 10,
  parameter int PRESC_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          b_addr_i,
  input  logic [7:0]          b_data_i,
  output logic [7:0]          b_data_o,
  input  logic                b_write_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_o
);
  localparam int HB = PWM_BITS - 8;
  localparam int CW = PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic                  en_q, center_q, dir_q, dir_d, period_q;
  logic [7:0]            presc_q;
  logic [PRESC_BITS-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [1:0]            ds;
  logic [7:0]            dither;
  logic                  tick, load, wr_ctl, wr_presc;

  logic [7:0] ch_rel, ch_num;
  logic [1:0] ch_off;
  logic       ch_hit;

  logic [PWM_BITS-1:0] shadow_w [CHANNELS];
  logic [CHANNELS-1:0] inv_w, chen_w;

  assign wr_ctl   = b_write_i && (b_addr_i == ADDR_CTL);
  assign wr_presc = b_write_i && (b_addr_i == ADDR_PRESC);
  assign ch_rel   = b_addr_i - CH_BASE;
  assign ch_num   = ch_rel / 8'(CH_STRIDE);
  assign ch_off   = ch_rel[1:0];
  assign ch_hit   = (b_addr_i >= CH_BASE) && (ch_num < 8'(CHANNELS));

  assign tick = (presc_cnt_q == PRESC_BITS'(presc_q));
  assign load = en_q && tick && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      center_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      if (wr_ctl) begin
        en_q     <= b_data_i[CTL_EN_BIT];
        center_q <= b_data_i[CTL_CENTER_BIT];
      end
      if (wr_presc) presc_q <= b_data_i;
    end
  end

`ifdef PWM_DITHER_EN
  logic [1:0] ds_q;
  logic [7:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i)       ds_q <= '0;
    else if (wr_ctl) ds_q <= b_data_i[1:0];
  end

  pwm_lfsr8 u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (load),
    .lfsr_o (lfsr)
  );

  assign ds     = ds_q;
  assign dither = lfsr >> ds_shift(ds_q);
`else
  assign ds     = 2'b00;
  assign dither = 8'h00;
`endif

  // Centre mode: up 0..MAX, down MAX-1..1, then 0 again, giving 2*MAX ticks.
  always_comb begin
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    presc_cnt_d = presc_cnt_q;
    if (!en_q) begin
      cnt_d       = '0;
      dir_d       = 1'b0;
      presc_cnt_d = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
      if (!center_q) begin
        cnt_d = cnt_q + PWM_BITS'(1);
      end else if (!dir_q) begin
        if (cnt_q == MAX) begin
          dir_d = 1'b1;
          cnt_d = MAX - PWM_BITS'(1);
        end else begin
          cnt_d = cnt_q + PWM_BITS'(1);
        end
      end else if (cnt_q == '0) begin
        dir_d = 1'b0;
        cnt_d = PWM_BITS'(1);
      end else begin
        cnt_d = cnt_q - PWM_BITS'(1);
      end
    end else begin
      presc_cnt_d = presc_cnt_q + PRESC_BITS'(1);
    end
    if (wr_ctl) dir_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      presc_cnt_q <= '0;
      period_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      presc_cnt_q <= presc_cnt_d;
      period_q    <= load;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic                wr_n;
    logic [HB-1:0]       temp_q;
    logic [PWM_BITS-1:0] shadow_q, active_q;
    logic                inv_q, chen_q, pwm_q;
    logic [CW-1:0]       cmp;

    assign wr_n = b_write_i && ch_hit && (ch_num == 8'(n));
    assign cmp  = {1'b0, active_q} + CW'(dither);

    // Active is loaded from the pre-write shadow, so a same-cycle write waits a period.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        temp_q   <= '0;
        shadow_q <= '0;
        active_q <= '0;
        inv_q    <= 1'b0;
        chen_q   <= 1'b0;
        pwm_q    <= 1'b0;
      end else begin
        if (wr_n && ch_off == OFF_DUTY_H) temp_q <= b_data_i[HB-1:0];
        if (wr_n && ch_off == OFF_DUTY_L) shadow_q <= {temp_q, b_data_i};
        if (wr_n && ch_off == OFF_CHCTL) begin
          inv_q  <= b_data_i[CHCTL_INV_BIT];
          chen_q <= b_data_i[CHCTL_CHEN_BIT];
        end
        if (!en_q || load) active_q <= shadow_q;
        pwm_q <= (en_q && chen_q && ({1'b0, cnt_q} < cmp)) ^ inv_q;
      end
    end

    assign shadow_w[n] = shadow_q;
    assign inv_w[n]    = inv_q;
    assign chen_w[n]   = chen_q;
    assign pwm_o[n]    = pwm_q;
  end

  always_comb begin
    b_data_o = 8'h00;
    if (b_addr_i == ADDR_CTL) begin
      b_data_o[CTL_EN_BIT]     = en_q;
      b_data_o[CTL_CENTER_BIT] = center_q;
      b_data_o[1:0]            = ds;
    end else if (b_addr_i == ADDR_PRESC) begin
      b_data_o = presc_q;
    end
    for (int n = 0; n < CHANNELS; n++) begin
      if (ch_hit && ch_num == 8'(n)) begin
        case (ch_off)
          OFF_DUTY_H: b_data_o = 8'(shadow_w[n] >> 8);
          OFF_DUTY_L: b_data_o = shadow_w[n][7:0];
          OFF_CHCTL: begin
            b_data_o[CHCTL_INV_BIT]  = inv_w[n];
            b_data_o[CHCTL_CHEN_BIT] = chen_w[n];
          end
          default: ;
        endcase
      end
    end
  end

  assign period_o = period_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized runs,
// every output cycle compared against a period-position reference model.
module tb_pwm_multi;
  localparam int CH   = 4;
  localparam int PB   = 10;
  localparam int MAXV = (1 << PB) - 1;
`ifdef PWM_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    b_addr, b_wdata, b_rdata;
  logic          b_write;
  logic [CH-1:0] pwm;
  logic          period;

  pwm_multi #(.CHANNELS(CH), .PWM_BITS(PB), .PRESC_BITS(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .b_addr_i  (b_addr),
    .b_data_i  (b_wdata),
    .b_data_o  (b_rdata),
    .b_write_i (b_write),
    .pwm_o     (pwm),
    .period_o  (period)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      if (bad >= 40) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  // Reference model: the counter is derived from the tick position within the period.
  bit m_en, m_center;
  int m_ds, m_presc, m_ticks, m_pc, m_lfsr;
  int m_shadow[CH], m_temp[CH], m_active[CH];
  bit m_inv[CH], m_chen[CH];
  bit exp_pwm[CH];
  bit exp_period;
  int hi_cnt, pulse_cnt;

  function automatic int lfsr_next(int v);
    int s = (v * 2) % 256;
    if (v >= 128) s = s ^ 'h1D;
    return s;
  endfunction

  function automatic int dither_of(int l, int ds);
    if (!DITH) return 0;
    case (ds)
      3:       return l / 2;
      2:       return l / 8;
      1:       return l / 32;
      default: return 0;
    endcase
  endfunction

  function automatic int period_ticks();
    return m_center ? 2 * MAXV : MAXV + 1;
  endfunction

  function automatic int cur_counter();
    if (!m_center || m_ticks <= MAXV) return m_ticks;
    return 2 * MAXV - m_ticks;
  endfunction

  function automatic int rd_model(int a);
    int ch, off;
    if (a == 0) return (m_en ? 128 : 0) + (m_center ? 64 : 0) + (DITH ? m_ds : 0);
    if (a == 1) return m_presc;
    if (a >= 16 && a < 16 + 4 * CH) begin
      ch  = (a - 16) / 4;
      off = (a - 16) % 4;
      case (off)
        0:       return m_shadow[ch] / 256;
        1:       return m_shadow[ch] % 256;
        2:       return (m_chen[ch] ? 2 : 0) + (m_inv[ch] ? 1 : 0);
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  function automatic void model_write(int a, int d);
    int ch;
    if (a == 0) begin
      m_en     = (d / 128) % 2 == 1;
      m_center = (d / 64) % 2 == 1;
      if (DITH) m_ds = d % 4;
    end else if (a == 1) begin
      m_presc = d;
    end else if (a >= 16 && a < 16 + 4 * CH) begin
      ch = (a - 16) / 4;
      case ((a - 16) % 4)
        0: m_temp[ch] = d % (1 << (PB - 8));
        1: m_shadow[ch] = m_temp[ch] * 256 + d;
        2: begin
          m_inv[ch]  = d % 2 == 1;
          m_chen[ch] = (d / 2) % 2 == 1;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_reset();
    m_en = 0; m_center = 0; m_ds = 0; m_presc = 0;
    m_ticks = 0; m_pc = 0; m_lfsr = 255;
    for (int n = 0; n < CH; n++) begin
      m_shadow[n] = 0; m_temp[n] = 0; m_active[n] = 0;
      m_inv[n] = 0; m_chen[n] = 0; exp_pwm[n] = 0;
    end
    exp_period = 0;
  endfunction

  task automatic cyc();
    bit tick, load;
    int cnt;
    cnt  = cur_counter();
    tick = m_en && (m_pc == m_presc);
    load = tick && (cnt == 0);
    for (int n = 0; n < CH; n++)
      exp_pwm[n] = (m_en && m_chen[n] &&
                    (cnt < m_active[n] + dither_of(m_lfsr, m_ds))) ^ m_inv[n];
    exp_period = load;
    if (!m_en) begin
      for (int n = 0; n < CH; n++) m_active[n] = m_shadow[n];
      m_ticks = 0;
      m_pc    = 0;
    end else begin
      if (load) begin
        for (int n = 0; n < CH; n++) m_active[n] = m_shadow[n];
        m_lfsr = lfsr_next(m_lfsr);
      end
      if (tick) begin
        m_pc    = 0;
        m_ticks = (m_ticks + 1) % period_ticks();
      end else begin
        m_pc++;
      end
    end
    if (b_write) model_write(int'(b_addr), int'(b_wdata));
    if (rst) model_reset();
    @(posedge clk);
    #1;
    for (int n = 0; n < CH; n++) chk($sformatf("pwm%0d", n), pwm[n], exp_pwm[n]);
    chk("period", period, exp_period);
    hi_cnt    += int'(pwm[0]);
    pulse_cnt += int'(period);
  endtask

  task automatic wr(input int a, input int d);
    b_addr  = a[7:0];
    b_wdata = d[7:0];
    b_write = 1'b1;
    cyc();
    b_write = 1'b0;
  endtask

  task automatic rd_chk(input int a);
    b_addr = a[7:0];
    #1;
    chk($sformatf("rd_%02h", a), b_rdata, rd_model(a));
  endtask

  task automatic sync_pulse(input int budget);
    int i = 0;
    while (period !== 1'b1 && i < budget) begin
      cyc();
      i++;
    end
    chk("sync_pulse", period, 1);
  endtask

  task automatic window(input string tag, input int n, input int hi_exp);
    hi_cnt = 0; pulse_cnt = 0;
    repeat (n) cyc();
    chk({tag, "_hi"}, hi_cnt, hi_exp);
    chk({tag, "_pulses"}, pulse_cnt, 1);
    chk({tag, "_end"}, period, 1);
  endtask

  initial begin
    int ctl;
    model_reset();
    rst = 1'b1; b_addr = '0; b_wdata = '0; b_write = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_pwm", pwm, 0);
    chk("rst_period", period, 0);
    rd_chk(8'h00); rd_chk(8'h01); rd_chk(8'h10); rd_chk(8'h11); rd_chk(8'h12);

    // Edge mode, duty 0x100: 256 of 1024 cycles high.
    wr(8'h10, 8'h01); wr(8'h11, 8'h00); wr(8'h12, 8'h02);
    rd_chk(8'h10); rd_chk(8'h11); rd_chk(8'h12);
    wr(8'h00, 8'h80);
    sync_pulse(50);
    window("edge", 1024, 256);

    // Mid-period shadow update: current period unchanged, next period 512.
    hi_cnt = 0; pulse_cnt = 0;
    repeat (500) cyc();
    wr(8'h10, 8'h02); wr(8'h11, 8'h00);
    repeat (1024 - 502) cyc();
    chk("shadow_cur_hi", hi_cnt, 256);
    chk("shadow_cur_end", period, 1);
    window("shadow_next", 1024, 512);

    // Atomic write: DUTY_H alone is invisible until DUTY_L commits.
    wr(8'h10, 8'h03);
    rd_chk(8'h10); rd_chk(8'h11);
    wr(8'h11, 8'hFF);
    rd_chk(8'h10); rd_chk(8'h11);
    sync_pulse(1100);
    window("atomic", 1024, 1023);

    // Centre mode, PRESC=1: 4092-clock period, (2*256-1) ticks high.
    wr(8'h00, 8'h00); wr(8'h01, 8'h01);
    wr(8'h10, 8'h01); wr(8'h11, 8'h00);
    wr(8'h00, 8'hC0);
    rd_chk(8'h00); rd_chk(8'h01);
    sync_pulse(50);
    window("centre", 4092, (2 * 256 - 1) * 2);

    // Invert / disable / reset mid-period.
    wr(8'h12, 8'h01);
    repeat (20) cyc();
    chk("inv_nochen", pwm[0], 1);
    wr(8'h00, 8'h00);
    repeat (5) cyc();
    chk("dis_out_inv", pwm[0], 1);
    rd_chk(8'h00);
    wr(8'h12, 8'h02); wr(8'h01, 8'h00); wr(8'h00, 8'h80);
    repeat (300) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_pwm", pwm, 0);
    rd_chk(8'h00); rd_chk(8'h01); rd_chk(8'h10); rd_chk(8'h11); rd_chk(8'h12);

    // Randomized rounds; CTL/PRESC only change while disabled.
    for (int r = 0; r < 10; r++) begin
      wr(8'h00, 8'h00);
      wr(8'h01, int'($urandom_range(0, 2)));
      for (int c = 0; c < CH; c++) begin
        wr(16 + 4 * c, int'($urandom_range(0, 255)));
        wr(17 + 4 * c, int'($urandom_range(0, 255)));
        wr(18 + 4 * c, int'($urandom_range(0, 3)));
      end
      ctl = 128 + 64 * int'($urandom_range(0, 1)) + int'($urandom_range(0, 3));
      if (r == 0) begin
        wr(8'h10, 8'h03); wr(8'h11, 8'hF0); wr(8'h12, 8'h02);
        ctl = 8'h83;
      end
      wr(8'h00, ctl);
      for (int c = 0; c < 2500; c++) begin
        case ($urandom_range(0, 63))
          0:       wr(int'($urandom_range(2, 255)), int'($urandom_range(0, 255)));
          1: begin
            rd_chk(int'($urandom_range(0, 255)));
            cyc();
          end
          default: cyc();
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
